// File: rtl/prbs_axis_gen.sv
// prbs_axis_gen: framed PRBS-31 AXI-Stream traffic source with programmable length, gap and frame count
module prbs_axis_gen #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 16
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    i_start,
  input  logic                    i_stop,
  input  logic [C_LEN_WIDTH-1:0]  i_frame_len,
  input  logic [C_LEN_WIDTH-1:0]  i_num_frames,
  input  logic [7:0]              i_gap,
  input  logic                    i_seed_load,
  input  logic [30:0]             i_seed,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                    m_axis_tlast,
  output logic                    m_axis_sof,
  output logic                    o_busy,
  output logic [C_LEN_WIDTH-1:0]  o_frame_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, GAP} state_e;
  localparam logic [30:0] LFSR_ONES = '1;
  state_e                   state_q, state_d;
  logic [30:0]              lfsr_q, lfsr_d;
  logic [C_LEN_WIDTH-1:0]   len_q, len_d, num_q, num_d, word_cnt_q, word_cnt_d, frame_cnt_q, frame_cnt_d;
  logic [C_LEN_WIDTH-1:0]   cnt_inc;
  logic [7:0]               gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic                     stop_q, stop_d;
  logic [30:0]              s;
  logic                     nb;
  logic [C_DATA_WIDTH-1:0]  word;
  logic                     valid, hs, last, stop_pend;
  // Unroll 32 LFSR steps; first generated bit lands in the MSB, so the low 31 bits are the next state
  always_comb begin
    s    = lfsr_q;
    nb   = 1'b0;
    word = '0;
    for (int k = 0; k < C_DATA_WIDTH; k++) begin
      nb = s[30] ^ s[27];
      word[C_DATA_WIDTH-1-k] = nb;
      s = {s[29:0], nb};
    end
  end
  assign valid     = state_q == RUN;
  assign hs        = valid & m_axis_tready;
  assign last      = word_cnt_q == len_q - C_LEN_WIDTH'(1);
  assign stop_pend = stop_q | i_stop;
  assign cnt_inc   = &frame_cnt_q ? frame_cnt_q : frame_cnt_q + C_LEN_WIDTH'(1);
  assign m_axis_tvalid = valid;
  assign m_axis_tdata  = valid ? word : '0;
  assign m_axis_sof    = valid & (word_cnt_q == '0);
  assign m_axis_tlast  = valid & last;
  assign o_busy        = state_q != IDLE;
  assign o_frame_cnt   = frame_cnt_q;
  // Frame sequencing: start/stop, word and gap counting, LFSR advance on handshake
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    len_d       = len_q;
    num_d       = num_q;
    gap_d       = gap_q;
    word_cnt_d  = word_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    frame_cnt_d = frame_cnt_q;
    stop_d      = stop_q;
    case (state_q)
      IDLE: begin
        if (i_seed_load) lfsr_d = (i_seed == '0) ? LFSR_ONES : i_seed;
        if (i_start && i_frame_len != '0) begin
          len_d       = i_frame_len;
          num_d       = i_num_frames;
          gap_d       = i_gap;
          word_cnt_d  = '0;
          frame_cnt_d = '0;
          stop_d      = i_stop;
          state_d     = RUN;
        end
      end
      RUN: begin
        stop_d = stop_pend;
        if (hs) begin
          lfsr_d     = word[30:0];
          word_cnt_d = last ? '0 : word_cnt_q + C_LEN_WIDTH'(1);
          if (last) begin
            frame_cnt_d = cnt_inc;
            if (stop_pend || (num_q != '0 && cnt_inc == num_q)) begin
              state_d = IDLE;
              stop_d  = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end
        end
      end
      GAP: begin
        stop_d    = stop_pend;
        gap_cnt_d = gap_cnt_q - 8'd1;
        if (stop_pend) begin
          state_d = IDLE;
          stop_d  = 1'b0;
        end else if (gap_cnt_q == 8'd1) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers
  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q     <= IDLE;
      lfsr_q      <= LFSR_ONES;
      len_q       <= '0;
      num_q       <= '0;
      gap_q       <= '0;
      word_cnt_q  <= '0;
      gap_cnt_q   <= '0;
      frame_cnt_q <= '0;
      stop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      len_q       <= len_d;
      num_q       <= num_d;
      gap_q       <= gap_d;
      word_cnt_q  <= word_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      stop_q      <= stop_d;
    end
  end
endmodule
